// File: rtl/issue_scheduler.sv
// rtl/issue_scheduler.sv - per-class issue select with latency-aware CDB reservation table
// Optional WAKEUP_BYPASS_EN: same-cycle CDB tag match counts as a ready source.
module issue_scheduler #(
  parameter int RS_SZ    = 16,
  parameter int NUM_ALU  = 3,
  parameter int NUM_MULT = 2,
  parameter int NUM_BR   = 1,
  parameter int NUM_CDB  = 3,
  parameter int MULT_LAT = 4,
  parameter int TAG_W    = 6,
  localparam int IDX_W   = $clog2(RS_SZ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      squash,
  input  logic [RS_SZ-1:0]          rs_valid,
  input  logic [RS_SZ-1:0]          rs_src1_ready,
  input  logic [RS_SZ-1:0]          rs_src2_ready,
  input  logic [RS_SZ*TAG_W-1:0]    rs_src1_tag,
  input  logic [RS_SZ*TAG_W-1:0]    rs_src2_tag,
  input  logic [RS_SZ*2-1:0]        rs_fu_type,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
  input  logic [NUM_MULT-1:0]       mult_ready,
  output logic [RS_SZ-1:0]          rs_issue_mask,
  output logic [NUM_ALU-1:0]        alu_iss_valid,
  output logic [NUM_ALU*IDX_W-1:0]  alu_iss_idx,
  output logic [NUM_MULT-1:0]       mult_iss_valid,
  output logic [NUM_MULT*IDX_W-1:0] mult_iss_idx,
  output logic [NUM_BR-1:0]         br_iss_valid,
  output logic [NUM_BR*IDX_W-1:0]   br_iss_idx
);

  localparam int CW = $clog2(NUM_CDB + 1);

  logic [RS_SZ-1:0]          src1_ok, src2_ok;
  logic [RS_SZ-1:0]          req_alu, req_mult, req_br;
  logic [CW-1:0]             res [1:MULT_LAT];
  logic [CW-1:0]             mult_cnt;
  logic [RS_SZ-1:0]          mask_n;
  logic [NUM_ALU-1:0]        alu_v_n;
  logic [NUM_ALU*IDX_W-1:0]  alu_i_n;
  logic [NUM_MULT-1:0]       mult_v_n;
  logic [NUM_MULT*IDX_W-1:0] mult_i_n;
  logic [NUM_BR-1:0]         br_v_n;
  logic [NUM_BR*IDX_W-1:0]   br_i_n;

`ifdef WAKEUP_BYPASS_EN
  always_comb begin
    src1_ok = rs_src1_ready;
    src2_ok = rs_src2_ready;
    for (int i = 0; i < RS_SZ; i++) begin
      for (int c = 0; c < NUM_CDB; c++) begin
        if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == rs_src1_tag[i*TAG_W +: TAG_W])
          src1_ok[i] = 1'b1;
        if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == rs_src2_tag[i*TAG_W +: TAG_W])
          src2_ok[i] = 1'b1;
      end
    end
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{cdb_valid, cdb_tag, rs_src1_tag, rs_src2_tag};
  assign src1_ok = rs_src1_ready;
  assign src2_ok = rs_src2_ready;
`endif

  always_comb begin
    req_alu  = '0;
    req_mult = '0;
    req_br   = '0;
    for (int i = 0; i < RS_SZ; i++) begin
      if (rs_valid[i] && src1_ok[i] && src2_ok[i]) begin
        case (rs_fu_type[i*2 +: 2])
          2'b00:   req_alu[i]  = 1'b1;
          2'b01:   req_mult[i] = 1'b1;
          2'b10:   req_br[i]   = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // ALU/BR share the CDB slot one cycle out; MULT competes against the newest reservation.
  always_comb begin
    int alu_n, br_n, mult_n, alu_cap, br_cap, mult_cap, rdy_n, seen;
    mask_n   = '0;
    alu_v_n  = '0;
    alu_i_n  = '0;
    mult_v_n = '0;
    mult_i_n = '0;
    br_v_n   = '0;
    br_i_n   = '0;
    alu_n    = 0;
    br_n     = 0;
    mult_n   = 0;
    seen     = 0;
    rdy_n    = $countones(mult_ready);
    if (reset || squash) begin
      alu_cap  = 0;
      mult_cap = 0;
    end else begin
      alu_cap  = NUM_CDB - int'(res[1]);
      mult_cap = NUM_CDB - int'(res[MULT_LAT]);
      if (rdy_n < mult_cap) mult_cap = rdy_n;
    end

    for (int i = 0; i < RS_SZ; i++) begin
      if (req_alu[i] && alu_n < alu_cap && alu_n < NUM_ALU) begin
        alu_v_n[alu_n]                 = 1'b1;
        alu_i_n[alu_n*IDX_W +: IDX_W]  = IDX_W'(i);
        mask_n[i]                      = 1'b1;
        alu_n++;
      end
    end

    br_cap = alu_cap - alu_n;
    for (int i = 0; i < RS_SZ; i++) begin
      if (req_br[i] && br_n < br_cap && br_n < NUM_BR) begin
        br_v_n[br_n]                = 1'b1;
        br_i_n[br_n*IDX_W +: IDX_W] = IDX_W'(i);
        mask_n[i]                   = 1'b1;
        br_n++;
      end
    end

    // The n-th MULT requester goes to the n-th ready unit.
    for (int i = 0; i < RS_SZ; i++) begin
      if (req_mult[i] && mult_n < mult_cap) begin
        seen = 0;
        for (int u = 0; u < NUM_MULT; u++) begin
          if (mult_ready[u]) begin
            if (seen == mult_n) begin
              mult_v_n[u]                = 1'b1;
              mult_i_n[u*IDX_W +: IDX_W] = IDX_W'(i);
            end
            seen++;
          end
        end
        mask_n[i] = 1'b1;
        mult_n++;
      end
    end
    mult_cnt = CW'(mult_n);
  end

  assign rs_issue_mask = mask_n;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alu_iss_valid  <= '0;
      alu_iss_idx    <= '0;
      mult_iss_valid <= '0;
      mult_iss_idx   <= '0;
      br_iss_valid   <= '0;
      br_iss_idx     <= '0;
      for (int d = 1; d <= MULT_LAT; d++) res[d] <= '0;
    end else begin
      alu_iss_valid  <= alu_v_n;
      alu_iss_idx    <= alu_i_n;
      mult_iss_valid <= mult_v_n;
      mult_iss_idx   <= mult_i_n;
      br_iss_valid   <= br_v_n;
      br_iss_idx     <= br_i_n;
      if (squash) begin
        for (int d = 1; d <= MULT_LAT; d++) res[d] <= '0;
      end else begin
        for (int d = 1; d < MULT_LAT; d++) res[d] <= res[d+1];
        res[MULT_LAT] <= mult_cnt;
      end
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// tb/tb_issue_scheduler.sv - randomized and directed checks of issue_scheduler against a grant-history model
module tb_issue_scheduler;
  localparam int RS_SZ = 16, NUM_ALU = 3, NUM_MULT = 2, NUM_BR = 1;
  localparam int NUM_CDB = 3, MULT_LAT = 4, TAG_W = 6, IDX_W = $clog2(RS_SZ);

  logic clock = 1'b0, reset = 1'b1, squash = 1'b0;
  logic [RS_SZ-1:0]          rs_valid, rs_src1_ready, rs_src2_ready;
  logic [RS_SZ*TAG_W-1:0]    rs_src1_tag, rs_src2_tag;
  logic [RS_SZ*2-1:0]        rs_fu_type;
  logic [NUM_CDB-1:0]        cdb_valid;
  logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
  logic [NUM_MULT-1:0]       mult_ready;
  logic [RS_SZ-1:0]          rs_issue_mask;
  logic [NUM_ALU-1:0]        alu_iss_valid;
  logic [NUM_ALU*IDX_W-1:0]  alu_iss_idx;
  logic [NUM_MULT-1:0]       mult_iss_valid;
  logic [NUM_MULT*IDX_W-1:0] mult_iss_idx;
  logic [NUM_BR-1:0]         br_iss_valid;
  logic [NUM_BR*IDX_W-1:0]   br_iss_idx;

  issue_scheduler #(.RS_SZ(RS_SZ), .NUM_ALU(NUM_ALU), .NUM_MULT(NUM_MULT), .NUM_BR(NUM_BR),
                    .NUM_CDB(NUM_CDB), .MULT_LAT(MULT_LAT), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset), .squash(squash), .rs_valid(rs_valid),
    .rs_src1_ready(rs_src1_ready), .rs_src2_ready(rs_src2_ready),
    .rs_src1_tag(rs_src1_tag), .rs_src2_tag(rs_src2_tag), .rs_fu_type(rs_fu_type),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .mult_ready(mult_ready),
    .rs_issue_mask(rs_issue_mask), .alu_iss_valid(alu_iss_valid), .alu_iss_idx(alu_iss_idx),
    .mult_iss_valid(mult_iss_valid), .mult_iss_idx(mult_iss_idx),
    .br_iss_valid(br_iss_valid), .br_iss_idx(br_iss_idx));

  always #5 clock = ~clock;

  int total = 0, bad = 0, cyc = 0;
  int hist [0:8191];  // MULT grants made in each absolute cycle (cleared by squash/reset)
  int e_av[NUM_ALU], e_ai[NUM_ALU], e_mv[NUM_MULT], e_mi[NUM_MULT], e_bv[NUM_BR], e_bi[NUM_BR];
  int n_av[NUM_ALU], n_ai[NUM_ALU], n_mv[NUM_MULT], n_mi[NUM_MULT], n_bv[NUM_BR], n_bi[NUM_BR];
  int e_mask, n_mt;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic bit on_cdb(input logic [TAG_W-1:0] t);
    bit m = 1'b0;
    for (int c = 0; c < NUM_CDB; c++)
      if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == t) m = 1'b1;
`ifdef WAKEUP_BYPASS_EN
    return m;
`else
    return m & 1'b0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8192; i++) hist[i] = 0;
    for (int k = 0; k < NUM_ALU; k++) begin e_av[k] = 0; e_ai[k] = 0; end
    for (int k = 0; k < NUM_MULT; k++) begin e_mv[k] = 0; e_mi[k] = 0; end
    for (int k = 0; k < NUM_BR; k++) begin e_bv[k] = 0; e_bi[k] = 0; end
  endtask

  task automatic model_comb();
    int aq[$], mq[$], bq[$], units[$];
    int r1, rt, at, bt, mt;
    for (int i = 0; i < RS_SZ; i++) begin
      bit ok1 = rs_src1_ready[i] || on_cdb(rs_src1_tag[i*TAG_W +: TAG_W]);
      bit ok2 = rs_src2_ready[i] || on_cdb(rs_src2_tag[i*TAG_W +: TAG_W]);
      if (rs_valid[i] && ok1 && ok2) begin
        if (rs_fu_type[i*2 +: 2] == 2'b00) aq.push_back(i);
        if (rs_fu_type[i*2 +: 2] == 2'b01) mq.push_back(i);
        if (rs_fu_type[i*2 +: 2] == 2'b10) bq.push_back(i);
      end
    end
    for (int u = 0; u < NUM_MULT; u++) if (mult_ready[u]) units.push_back(u);
    r1 = (cyc >= MULT_LAT) ? hist[cyc-MULT_LAT] : 0;
    rt = (cyc >= 1) ? hist[cyc-1] : 0;
    at = min2(min2(NUM_ALU, aq.size()), NUM_CDB - r1);
    bt = min2(min2(NUM_BR, bq.size()), NUM_CDB - r1 - at);
    mt = min2(min2(mq.size(), units.size()), NUM_CDB - rt);
    if (squash) begin at = 0; bt = 0; mt = 0; end
    e_mask = 0;
    for (int k = 0; k < NUM_ALU; k++) begin n_av[k] = (k < at); n_ai[k] = (k < at) ? aq[k] : 0; end
    for (int k = 0; k < NUM_BR; k++) begin n_bv[k] = (k < bt); n_bi[k] = (k < bt) ? bq[k] : 0; end
    for (int k = 0; k < NUM_MULT; k++) begin n_mv[k] = 0; n_mi[k] = 0; end
    for (int j = 0; j < mt; j++) begin n_mv[units[j]] = 1; n_mi[units[j]] = mq[j]; end
    for (int k = 0; k < at; k++) e_mask |= (1 << aq[k]);
    for (int k = 0; k < bt; k++) e_mask |= (1 << bq[k]);
    for (int k = 0; k < mt; k++) e_mask |= (1 << mq[k]);
    n_mt = mt;
  endtask

  task automatic model_seq();
    e_av = n_av; e_ai = n_ai; e_mv = n_mv; e_mi = n_mi; e_bv = n_bv; e_bi = n_bi;
    hist[cyc] = n_mt;
    if (squash) for (int i = 0; i <= cyc; i++) hist[i] = 0;
    cyc++;
  endtask

  task automatic check_lanes();
    for (int k = 0; k < NUM_ALU; k++) begin
      chk($sformatf("alu_valid%0d", k), int'(alu_iss_valid[k]), e_av[k]);
      chk($sformatf("alu_idx%0d", k), int'(alu_iss_idx[k*IDX_W +: IDX_W]), e_ai[k]);
    end
    for (int k = 0; k < NUM_MULT; k++) begin
      chk($sformatf("mult_valid%0d", k), int'(mult_iss_valid[k]), e_mv[k]);
      chk($sformatf("mult_idx%0d", k), int'(mult_iss_idx[k*IDX_W +: IDX_W]), e_mi[k]);
    end
    for (int k = 0; k < NUM_BR; k++) begin
      chk($sformatf("br_valid%0d", k), int'(br_iss_valid[k]), e_bv[k]);
      chk($sformatf("br_idx%0d", k), int'(br_iss_idx[k*IDX_W +: IDX_W]), e_bi[k]);
    end
  endtask

  // Called just after inputs change, away from the posedge.
  task automatic step();
    #1;
    model_comb();
    chk("mask_model", int'(rs_issue_mask), e_mask);
    @(posedge clock);
    model_seq();
    @(negedge clock);
    check_lanes();
  endtask

  task automatic idle();
    squash = 0; rs_valid = '0; rs_src1_ready = '1; rs_src2_ready = '1;
    rs_src1_tag = '0; rs_src2_tag = '0; rs_fu_type = '1;
    cdb_valid = '0; cdb_tag = '0; mult_ready = '1;
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < RS_SZ; i++) begin
      rs_valid[i]      = ($urandom_range(0, 3) != 0);
      rs_src1_ready[i] = ($urandom_range(0, 3) != 0);
      rs_src2_ready[i] = ($urandom_range(0, 4) != 0);
      rs_src1_tag[i*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, 7));
      rs_src2_tag[i*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, 7));
      rs_fu_type[i*2 +: 2] = 2'($urandom_range(0, 3));
    end
    for (int c = 0; c < NUM_CDB; c++) begin
      cdb_valid[c] = $urandom_range(0, 1) != 0;
      cdb_tag[c*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, 7));
    end
    mult_ready = NUM_MULT'($urandom);
    squash = ($urandom_range(0, 19) == 0);
  endtask

  initial begin
    idle();
    model_reset();
    rs_valid = '1;
    rs_fu_type = '0;
    #3;
    chk("reset_mask", int'(rs_issue_mask), 0);
    chk("reset_alu_valid", int'(alu_iss_valid), 0);
    @(negedge clock); @(negedge clock);
    reset = 0;
    check_lanes();

    // Five ready ALU entries: three lowest issue.
    idle(); rs_valid = 16'h028D; rs_fu_type = '0;
    #1 chk("alu5_mask", int'(rs_issue_mask), 16'h000D);
    step();
    chk("alu5_lanes_valid", int'(alu_iss_valid), 3'b111);
    chk("alu5_lane2_idx", int'(alu_iss_idx[2*IDX_W +: IDX_W]), 3);

    // No ready MULT unit, then only unit 1.
    idle(); rs_valid = 16'h0120; rs_fu_type[5*2 +: 2] = 2'b01; rs_fu_type[8*2 +: 2] = 2'b01;
    mult_ready = 2'b00;
    #1 chk("mult_stall_mask", int'(rs_issue_mask), 0);
    step();
    mult_ready = 2'b10;
    #1 chk("mult_unit1_mask", int'(rs_issue_mask), 16'h0020);
    step();
    chk("mult_unit1_valid", int'(mult_iss_valid), 2'b10);
    chk("mult_unit1_idx", int'(mult_iss_idx[IDX_W +: IDX_W]), 5);

    // Squash with ready requests.
    idle(); rs_valid = 16'h0007; rs_fu_type = '0; squash = 1;
    #1 chk("squash_mask", int'(rs_issue_mask), 0);
    step();
    chk("squash_alu_valid", int'(alu_iss_valid), 0);

    // One MULT grant reserves a CDB slot MULT_LAT cycles later.
    idle(); rs_valid = 16'h0002; rs_fu_type[1*2 +: 2] = 2'b01;
    step();
    idle(); for (int k = 0; k < 3; k++) step();
    rs_valid = 16'h0007; rs_fu_type = '0;
    #1 chk("res_cap_mask", int'(rs_issue_mask), 16'h0003);
    step();

    // Same again but a squash drops the reservation.
    idle(); rs_valid = 16'h0002; rs_fu_type[1*2 +: 2] = 2'b01;
    step();
    idle(); squash = 1; step();
    idle(); for (int k = 0; k < 2; k++) step();
    rs_valid = 16'h0007; rs_fu_type = '0;
    #1 chk("res_squashed_mask", int'(rs_issue_mask), 16'h0007);
    step();

    // Same-cycle wakeup of entry 4 through the CDB.
    idle(); rs_valid = 16'h0010; rs_fu_type = '0; rs_src1_ready[4] = 1'b0;
    rs_src1_tag[4*TAG_W +: TAG_W] = 6'h12; cdb_valid = 3'b001; cdb_tag[0 +: TAG_W] = 6'h12;
`ifdef WAKEUP_BYPASS_EN
    #1 chk("bypass_mask", int'(rs_issue_mask), 16'h0010);
`else
    #1 chk("bypass_mask", int'(rs_issue_mask), 0);
`endif
    step();
    rs_src1_ready[4] = 1'b1; cdb_valid = '0;
    #1 chk("wakeup_next_mask", int'(rs_issue_mask), 16'h0010);
    step();

    for (int n = 0; n < 1500; n++) begin
      randomize_inputs();
      step();
      if (n == 700) begin
        reset = 1;
        #1;
        chk("midreset_mask", int'(rs_issue_mask), 0);
        chk("midreset_alu_valid", int'(alu_iss_valid), 0);
        chk("midreset_mult_valid", int'(mult_iss_valid), 0);
        model_reset();
        @(negedge clock);
        reset = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
